// File: rtl/umem_if.sv
// umem_if: request/grant/response bundle between requesters, the arbiter and the SRAM port.
interface umem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [3:0]        d_wen;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic [ADDR_W-3:0] mem_addr;
    logic [3:0]        mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_addr, d_wen, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_addr, mem_wen, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_addr, d_wen, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_en, mem_addr, mem_wen, mem_wdata
    );
endinterface

// File: rtl/umem_arbiter.sv
// umem_arbiter: shares one 1-cycle-latency SRAM port between fetch and load/store,
// data first with a starvation bound on fetch, and routes read data to its owner.
module umem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input logic    clk,
    input logic    rst,
    umem_if.slave  bus
);
    typedef enum logic [1:0] {RSP_NONE, RSP_IF, RSP_D} rsp_e;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    rsp_e       state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       if_sel, d_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RSP_NONE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Data wins a conflict unless fetch has already waited STARVE_MAX cycles.
    always_comb begin
        d_sel    = bus.d_req && !(bus.if_req && starve_q == SMAX);
        if_sel   = bus.if_req && !d_sel;
        starve_d = (bus.if_req && !if_sel) ? ((starve_q == SMAX) ? starve_q : starve_q + 4'd1) : 4'd0;
        state_d  = if_sel ? RSP_IF : (d_sel && bus.d_wen == 4'd0) ? RSP_D : RSP_NONE;
    end

    assign bus.if_gnt    = if_sel;
    assign bus.d_gnt     = d_sel;
    assign bus.mem_en    = if_sel || d_sel;
    assign bus.mem_addr  = if_sel ? bus.if_addr[ADDR_W-1:2] : bus.d_addr[ADDR_W-1:2];
    assign bus.mem_wen   = d_sel ? bus.d_wen : 4'd0;
    assign bus.mem_wdata = bus.d_wdata;
    assign bus.if_rvalid = (state_q == RSP_IF);
    assign bus.d_rvalid  = (state_q == RSP_D);
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_umem_arbiter.sv
// tb_umem_arbiter: table-driven check of grant selection, starvation and response routing,
// plus hand sequences for reset in the middle of an outstanding read.
module tb_umem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total = 0;

    always #5 clk = ~clk;

    umem_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    umem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic [31:0] da;
        logic [3:0]  dw;
        logic [31:0] dwd;
        logic [31:0] mrd;
        logic        eig;
        logic        edg;
        logic        emen;
        logic [29:0] eaddr;
        logic [3:0]  ewen;
        logic        eirv;
        logic        edrv;
    } vec_t;

    vec_t v[16];

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", n, got, exp);
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da,
                         input logic [3:0] dw, input logic [31:0] dwd, input logic [31:0] mrd);
        bus.if_req    = ir;
        bus.if_addr   = ia;
        bus.d_req     = dr;
        bus.d_addr    = da;
        bus.d_wen     = dw;
        bus.d_wdata   = dwd;
        bus.mem_rdata = mrd;
    endtask

    initial begin
        v[0]  = '{1'b0, 32'h0,   1'b0, 32'h0,   4'h0, 32'h0,    32'h0,         1'b0, 1'b0, 1'b0, 30'h0,  4'h0, 1'b0, 1'b0};
        v[1]  = '{1'b1, 32'h10,  1'b0, 32'h0,   4'h0, 32'h0,    32'h0,         1'b1, 1'b0, 1'b1, 30'h4,  4'h0, 1'b0, 1'b0};
        v[2]  = '{1'b0, 32'h0,   1'b0, 32'h0,   4'h0, 32'h0,    32'hCAFE_0001, 1'b0, 1'b0, 1'b0, 30'h0,  4'h0, 1'b1, 1'b0};
        v[3]  = '{1'b1, 32'h20,  1'b1, 32'h200, 4'h0, 32'h0,    32'h0,         1'b0, 1'b1, 1'b1, 30'h80, 4'h0, 1'b0, 1'b0};
        v[4]  = '{1'b1, 32'h20,  1'b0, 32'h0,   4'h0, 32'h0,    32'h1234_5678, 1'b1, 1'b0, 1'b1, 30'h8,  4'h0, 1'b0, 1'b1};
        v[5]  = '{1'b0, 32'h0,   1'b1, 32'h100, 4'h3, 32'hBEEF, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b1, 30'h40, 4'h3, 1'b1, 1'b0};
        v[6]  = '{1'b0, 32'h0,   1'b0, 32'h0,   4'h0, 32'h0,    32'h5555,      1'b0, 1'b0, 1'b0, 30'h0,  4'h0, 1'b0, 1'b0};
        v[7]  = '{1'b1, 32'h30,  1'b0, 32'h0,   4'h0, 32'h0,    32'h0,         1'b1, 1'b0, 1'b1, 30'hC,  4'h0, 1'b0, 1'b0};
        v[8]  = '{1'b0, 32'h0,   1'b1, 32'h44,  4'h0, 32'h0,    32'hAAAA_0000, 1'b0, 1'b1, 1'b1, 30'h11, 4'h0, 1'b1, 1'b0};
        v[9]  = '{1'b0, 32'h0,   1'b0, 32'h0,   4'h0, 32'h0,    32'h7777,      1'b0, 1'b0, 1'b0, 30'h0,  4'h0, 1'b0, 1'b1};
        v[10] = '{1'b1, 32'h40,  1'b1, 32'h80,  4'h0, 32'h0,    32'h0,         1'b0, 1'b1, 1'b1, 30'h20, 4'h0, 1'b0, 1'b0};
        v[11] = '{1'b1, 32'h40,  1'b1, 32'h80,  4'h0, 32'h0,    32'h11,        1'b0, 1'b1, 1'b1, 30'h20, 4'h0, 1'b0, 1'b1};
        v[12] = '{1'b1, 32'h40,  1'b1, 32'h80,  4'h0, 32'h0,    32'h22,        1'b0, 1'b1, 1'b1, 30'h20, 4'h0, 1'b0, 1'b1};
        v[13] = '{1'b1, 32'h40,  1'b1, 32'h80,  4'h0, 32'h0,    32'h33,        1'b1, 1'b0, 1'b1, 30'h10, 4'h0, 1'b0, 1'b1};
        v[14] = '{1'b1, 32'h40,  1'b1, 32'h80,  4'h0, 32'h0,    32'h44,        1'b0, 1'b1, 1'b1, 30'h20, 4'h0, 1'b1, 1'b0};
        v[15] = '{1'b0, 32'h0,   1'b0, 32'h0,   4'h0, 32'h0,    32'h55,        1'b0, 1'b0, 1'b0, 30'h0,  4'h0, 1'b0, 1'b1};

        drive(1'b0, '0, 1'b0, '0, 4'h0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset if_rvalid", {31'b0, bus.if_rvalid}, 32'd0);
        chk("reset d_rvalid", {31'b0, bus.d_rvalid}, 32'd0);
        chk("reset mem_en", {31'b0, bus.mem_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(v[i].ir, v[i].ia, v[i].dr, v[i].da, v[i].dw, v[i].dwd, v[i].mrd);
            #2;
            chk($sformatf("v%0d if_gnt", i), {31'b0, bus.if_gnt}, {31'b0, v[i].eig});
            chk($sformatf("v%0d d_gnt", i), {31'b0, bus.d_gnt}, {31'b0, v[i].edg});
            chk($sformatf("v%0d mem_en", i), {31'b0, bus.mem_en}, {31'b0, v[i].emen});
            chk($sformatf("v%0d if_rvalid", i), {31'b0, bus.if_rvalid}, {31'b0, v[i].eirv});
            chk($sformatf("v%0d d_rvalid", i), {31'b0, bus.d_rvalid}, {31'b0, v[i].edrv});
            chk($sformatf("v%0d gnt exclusive", i), {31'b0, bus.if_gnt & bus.d_gnt}, 32'd0);
            chk($sformatf("v%0d rvalid exclusive", i), {31'b0, bus.if_rvalid & bus.d_rvalid}, 32'd0);
            if (v[i].emen) begin
                chk($sformatf("v%0d mem_addr", i), {2'b0, bus.mem_addr}, {2'b0, v[i].eaddr});
                chk($sformatf("v%0d mem_wen", i), {28'b0, bus.mem_wen}, {28'b0, v[i].ewen});
            end
            if (v[i].edg && v[i].dw != 4'h0)
                chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, v[i].dwd);
            if (v[i].eirv) chk($sformatf("v%0d if_rdata", i), bus.if_rdata, v[i].mrd);
            if (v[i].edrv) chk($sformatf("v%0d d_rdata", i), bus.d_rdata, v[i].mrd);
        end

        // Reset while a fetch read is outstanding drops the response at once.
        @(negedge clk);
        drive(1'b1, 32'h50, 1'b0, '0, 4'h0, '0, 32'h9999);
        #2;
        chk("rstA if_gnt", {31'b0, bus.if_gnt}, 32'd1);
        @(posedge clk);
        #1;
        drive(1'b0, '0, 1'b0, '0, 4'h0, '0, 32'h9999);
        chk("rstA if_rvalid before", {31'b0, bus.if_rvalid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rstA if_rvalid dropped", {31'b0, bus.if_rvalid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rstA if_rvalid after", {31'b0, bus.if_rvalid}, 32'd0);
        chk("rstA d_rvalid after", {31'b0, bus.d_rvalid}, 32'd0);

        // Reset with starvation count built up clears it: fetch must wait a full 3 cycles again.
        @(negedge clk);
        drive(1'b1, 32'h60, 1'b1, 32'h90, 4'h0, '0, 32'h0);
        #2;
        chk("rstB d_gnt c0", {31'b0, bus.d_gnt}, 32'd1);
        @(negedge clk);
        #2;
        chk("rstB d_gnt c1", {31'b0, bus.d_gnt}, 32'd1);
        chk("rstB d_rvalid c1", {31'b0, bus.d_rvalid}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rstB d_rvalid dropped", {31'b0, bus.d_rvalid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #2;
            chk($sformatf("rstB post k%0d if_gnt", k), {31'b0, bus.if_gnt}, (k == 3) ? 32'd1 : 32'd0);
            chk($sformatf("rstB post k%0d d_gnt", k), {31'b0, bus.d_gnt}, (k == 3) ? 32'd0 : 32'd1);
        end

        @(negedge clk);
        drive(1'b0, '0, 1'b0, '0, 4'h0, '0, '0);
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule

// File: doc/umem_arbiter.md
# umem_arbiter

Arbiter and sequencer for the single-port unified instruction/data memory. Shares one synchronous SRAM port (1-cycle read latency) between the instruction-fetch requester and the load/store requester. Data accesses win by default; a starvation counter forces a fetch grant after a bounded wait. Read data is routed back to the owning requester one cycle after grant.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, data width (4 byte lanes)
- STARVE_MAX, 3, consecutive denied-fetch cycles before fetch gets forced priority (1..15)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_W  fetch data
- d_req  in  1  data request, held until d_gnt
- d_addr  in  ADDR_W  data address
- d_wen  in  4  byte write enables; 0 = load, nonzero = store
- d_wdata  in  DATA_W  store data, pre-aligned to lanes
- d_gnt  out  1  data access accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_W  load data
- mem_en  out  1  SRAM port enable
- mem_addr  out  ADDR_W-2  SRAM word address (addr[ADDR_W-1:2])
- mem_wen  out  4  SRAM byte write enables
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid cycle after mem_en read

## Operation
- Grant selection (combinational, same cycle as request):
  - only d_req -> data; only if_req -> fetch; neither -> no grant, mem_en=0.
  - both -> data, unless starve_cnt == STARVE_MAX, then fetch.
- if_gnt/d_gnt asserted only alongside own req; never both in one cycle.
- Granted request drives mem_en=1, mem_addr, mem_wen (fetch: 0; data: d_wen), mem_wdata (d_wdata; don't-care for reads).
- starve_cnt (4-bit): cycle with if_req=1 and if_gnt=0 -> increment, saturate at STARVE_MAX; if_gnt=1 or if_req=0 -> clear to 0.
- Response FSM, registered, encodes the owner of the read issued last cycle:
  - RSP_NONE: no read outstanding.
  - RSP_IF: fetch read granted previous cycle.
  - RSP_D: load (d_wen==0) granted previous cycle.
  - Next state each cycle: fetch grant -> RSP_IF; load grant -> RSP_D; store grant or no grant -> RSP_NONE. Any state reaches any state.
- if_rvalid = (state==RSP_IF); d_rvalid = (state==RSP_D). Both rdata outputs pass mem_rdata through; content only meaningful with matching rvalid.
- Stores complete at d_gnt; no d_rvalid is generated for a store.
- Requests are not queued; a requester whose req is not granted keeps req/addr/wdata stable.

## Timing
- Reset (async assert, sync deassert by system): state=RSP_NONE, starve_cnt=0; if_rvalid=d_rvalid=0 immediately. gnt/mem outputs are combinational from req and valid the cycle after reset releases.
- Grant latency 0 cycles from req when selected; read data latency exactly 1 cycle after gnt.
- Full pipelining: a new grant every cycle; response of cycle N and grant of cycle N+1 coexist.
- Reset during an outstanding read: response dropped, rvalid stays 0.
- Fetch wait with continuous d_req bounded by STARVE_MAX cycles: fetch granted on cycle STARVE_MAX+1 of waiting.
- Simultaneous req change and grant: arbiter only samples current-cycle req; no latched requests.

## Test plan
- Fetch only: if_req=1, if_addr=0x0000_0010 -> if_gnt same cycle, mem_addr=0x4, mem_wen=0; next cycle if_rvalid=1, if_rdata=mem_rdata.
- Load vs fetch conflict: both req for one cycle -> d_gnt=1, if_gnt=0, starve_cnt=1; next cycle d_rvalid=1, and if_gnt=1 if d_req drops.
- Store: d_req=1, d_wen=4'b0011, d_wdata=0x0000_BEEF, d_addr=0x100 -> mem_wen=0011, mem_addr=0x40; next cycle d_rvalid=0, state RSP_NONE.
- Starvation: if_req and d_req held continuously, STARVE_MAX=3 -> d_gnt on cycles 1-3, if_gnt on cycle 4, starve_cnt back to 0, then data again on cycle 5.
- Back-to-back: fetch grant cycle 0, load grant cycle 1 -> if_rvalid cycle 1, d_rvalid cycle 2, never both high.
- Reset mid-read: assert rst in cycle after fetch grant -> if_rvalid falls to 0 immediately, starve_cnt=0 after release.
